// File: rtl/dm_access_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage (M0) and a debug/DMA loader (M1).
// Define DM_ARB_RR_EN for round-robin tie-breaking in IDLE; otherwise M0 has fixed priority.
module dm_access_arbiter #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [2:0]  m0_type,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic [31:0] m0_pc,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [2:0]  m1_type,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic [31:0] m1_pc,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic        dm_we,
  output logic [2:0]  dm_type,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  lock_cnt_q;
  logic [3:0]  lock_cnt_inc;
  logic        lock_enter;
  logic        lock_done;

`ifdef DM_ARB_RR_EN
  logic        last_owner_q;  // 1 = M1 was granted last
`endif

  logic        gnt0;
  logic        gnt1;
  logic        any_gnt;

  logic        sel_lock;
  logic        sel_we;
  logic [2:0]  sel_type;
  logic [31:0] sel_addr;
  logic [31:0] sel_wd;
  logic [31:0] sel_pc;

  logic        misalign;
  logic        out_of_range;
  logic        acc_err;
  logic [31:0] rsp_rdata_d;

  logic        m0_rvalid_q;
  logic        m1_rvalid_q;
  logic        m0_err_q;
  logic        m1_err_q;
  logic [31:0] m0_rdata_q;
  logic [31:0] m1_rdata_q;

  // Ownership restricts grants to the locking master; ties only arise in IDLE.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      OWN0: gnt0 = m0_req;
      OWN1: gnt1 = m1_req;
      default: begin
        if (m0_req && m1_req) begin
`ifdef DM_ARB_RR_EN
          gnt0 = last_owner_q;
          gnt1 = ~last_owner_q;
`else
          gnt0 = 1'b1;
`endif
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end
    endcase
  end

  assign any_gnt = gnt0 | gnt1;

  always_comb begin
    sel_lock = 1'b0;
    sel_we   = 1'b0;
    sel_type = '0;
    sel_addr = '0;
    sel_wd   = '0;
    sel_pc   = '0;
    if (gnt0) begin
      sel_lock = m0_lock;
      sel_we   = m0_we;
      sel_type = m0_type;
      sel_addr = m0_addr;
      sel_wd   = m0_wd;
      sel_pc   = m0_pc;
    end else if (gnt1) begin
      sel_lock = m1_lock;
      sel_we   = m1_we;
      sel_type = m1_type;
      sel_addr = m1_addr;
      sel_wd   = m1_wd;
      sel_pc   = m1_pc;
    end
  end

  // Word needs 4-byte alignment, halves 2-byte; bytes and WL/WR are unaligned by nature.
  always_comb begin
    misalign = 1'b0;
    case (sel_type)
      3'b000:         misalign = (sel_addr[1:0] != 2'b00);
      3'b010, 3'b011: misalign = sel_addr[0];
      default:        misalign = 1'b0;
    endcase
  end

  assign out_of_range = ((sel_addr >> WIDTH) != 32'd0);
  assign acc_err      = any_gnt & (misalign | out_of_range);
  assign rsp_rdata_d  = (sel_we | acc_err) ? '0 : dm_rd;

  assign dm_we   = sel_we & ~acc_err;
  assign dm_type = sel_type;
  assign dm_addr = sel_addr;
  assign dm_wd   = sel_wd;
  assign dm_pc   = sel_pc;

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  assign lock_cnt_inc = lock_cnt_q + 4'd1;
  assign lock_enter   = sel_lock && (LOCK_MAX > 32'd1);
  assign lock_done    = ~sel_lock || (32'(lock_cnt_inc) >= LOCK_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lock_cnt_q   <= '0;
`ifdef DM_ARB_RR_EN
      last_owner_q <= 1'b1;
`endif
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      m0_rvalid_q <= gnt0;
      m1_rvalid_q <= gnt1;
      m0_err_q    <= gnt0 & acc_err;
      m1_err_q    <= gnt1 & acc_err;
      m0_rdata_q  <= gnt0 ? rsp_rdata_d : '0;
      m1_rdata_q  <= gnt1 ? rsp_rdata_d : '0;
      if (any_gnt) begin
`ifdef DM_ARB_RR_EN
        last_owner_q <= gnt1;
`endif
        case (state_q)
          IDLE: begin
            if (lock_enter) begin
              state_q    <= gnt1 ? OWN1 : OWN0;
              lock_cnt_q <= 4'd1;
            end
          end
          default: begin
            if (lock_done) begin
              state_q    <= IDLE;
              lock_cnt_q <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_inc;
            end
          end
        endcase
      end
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
